fxp_addsub_scheduler: RTL and testbench
=======================================

// Module: fxp_addsub_scheduler
// PURPOSE
//  Shares one fixed-point add/sub datapath between N_REQ requesters. Round-robin
//  arbitration, one operation per cycle, two-stage pipeline. Output register with
//  valid/ready backpressure. Returns a signed, saturating result tagged with the
//  requester id. Sits between the filter-stage sequencers and the shared adder.
// PARAMETERS
//  N_REQ     4   number of requesters (>=2)
//  DATA_W    8   operand/result width, signed two's complement
//  FRAC_W    4   fractional bits (Q(DATA_W-FRAC_W).FRAC_W); identical for a, b, result
//  SATURATE  1   1: clamp on overflow; 0: wrap (o_rsp_ovf still flags)
// PORTS
//  i_clk        in   1               clock, rising edge
//  i_reset_n    in   1               synchronous, active-low reset
//  i_req_valid  in   N_REQ           per-requester operation valid
//  o_req_ready  out  N_REQ           per-requester accept; at most one bit high
//  i_req_a      in   N_REQ*DATA_W    operand A, requester i at [i*DATA_W +: DATA_W]
//  i_req_b      in   N_REQ*DATA_W    operand B, same packing
//  i_req_sub    in   N_REQ           0: a+b, 1: a-b
//  o_rsp_valid  out  1               result valid
//  i_rsp_ready  in   1               downstream accept
//  o_rsp_id     out  $clog2(N_REQ)   requester id of result
//  o_rsp_data   out  DATA_W          result
//  o_rsp_ovf    out  1               overflow occurred
//  o_busy       out  1               any op in flight (s1 or output valid)
// BEHAVIOUR
//  - Reset: when i_reset_n=0 at a clock edge, all outputs go to 0, all pipeline
//    valids clear, and the RR pointer is set to N_REQ-1, so requester 0 wins first.
//  - Reset mid-operation: in-flight ops are dropped silently; no response is emitted.
//  - Transfer: occurs when i_req_valid[i] & o_req_ready[i] at a clock edge.
//  - o_req_ready[i] = grant[i] & s1_free.
//    - grant is one-hot over i_req_valid.
//    - Ready may depend combinationally on valid.
//  - Arbitration: search starts at ptr+1, modulo N_REQ.
//    - ptr <= granted id only on a transfer.
//    - A stalled grant does not rotate the pointer.
//  - Stage s1 register: valid, id, a, b, sub.
//    - s1_free = !s1_valid | out_free.
//  - Output stage: out_free = !o_rsp_valid | i_rsp_ready.
//    - s1 moves to the output when s1_valid & out_free.
//  - Latency: a transfer at edge k gives o_rsp_valid at edge k+2 with no stall.
//    Throughput is 1 op/cycle.
//  - Stall: while o_rsp_valid & !i_rsp_ready, o_rsp_* hold stable.
//    When s1 is also full, all o_req_ready are 0. No op is lost or duplicated.
//  - Arithmetic:
//    - Sign-extend a and b to DATA_W+1 bits; sum = a + (sub ? -b : b).
//    - ovf = sum[DATA_W] ^ sum[DATA_W-1].
//    - With SATURATE=1 and ovf: positive -> 2^(DATA_W-1)-1, negative -> -2^(DATA_W-1).
//    - Otherwise the result is sum[DATA_W-1:0].
//    - a - (-2^(DATA_W-1)) is handled by the extended width, not by negating b in DATA_W bits.
//  - o_busy = s1_valid | o_rsp_valid.
//  - No requester valid: no grant, the pointer holds, and bubbles propagate.
// STRUCTURE
//  - Package fxp_pkg:
//    - DATA_W/FRAC_W defaults
//    - OP_ADD=1'b0 / OP_SUB=1'b1 constants
//    - functions fxp_sat_max(w) and fxp_sat_min(w)
//  - Sub-module fxp_rr_arbiter #(N_REQ):
//    - in: req[N], advance
//    - out: grant one-hot, grant_id
//    - owns the pointer
//  - Top holds s1, the output register, and the add/sub/saturate logic.
// TESTING
//  1 Basic add (req0 only): a=0x10, b=0x08, sub=0 at edge k -> edge k+2: valid=1, id=0,
//    data=0x18, ovf=0.
//  2 Saturation: a=0x70, b=0x20, add -> 0x7F, ovf=1.
//    a=0x80, b=0x01, sub -> 0x80, ovf=1.
//    a=0x00, b=0x80, sub -> 0x7F, ovf=1.
//    SATURATE=0 with a=0x70, b=0x20 -> 0x90, ovf=1.
//  3 Fairness: all 4 valid continuously with i_rsp_ready=1 -> ids 0,1,2,3,0,1.
//    One response per cycle, no gaps.
//  4 Backpressure: all valid, i_rsp_ready=0 for 4 cycles.
//    Expect o_rsp_* frozen and o_req_ready=0 after s1 fills.
//    On release, responses resume in order with none dropped.
//  5 Reset mid-op: assert i_reset_n=0 for one edge with s1 and the output full.
//    -> o_rsp_valid=0, o_busy=0 next cycle.
//    With all valid afterwards, the first grant goes to req0.
//  6 Sparse requests: only req3 and req1 valid, ptr=1 -> grant order 3,1,3.
//    A grant held with i_rsp_ready=0 does not advance the pointer.

Source files
------------

// File: rtl/fxp_pkg.sv
// Shared constants and helpers for the fixed-point add/sub scheduler.
// Provides default widths, the op encoding and saturation bound helpers.
// Contents: DATA_W_DEF, FRAC_W_DEF, OP_ADD/OP_SUB, fxp_sat_max(w), fxp_sat_min(w).
package fxp_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int FRAC_W_DEF = 4;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  // Largest positive value of a w-bit two's complement number.
  function automatic logic signed [31:0] fxp_sat_max(input int w);
    return (32'sd1 <<< (w - 1)) - 32'sd1;
  endfunction

  // Most negative value of a w-bit two's complement number.
  function automatic logic signed [31:0] fxp_sat_min(input int w);
    return -(32'sd1 <<< (w - 1));
  endfunction

endpackage

// File: rtl/fxp_rr_arbiter.sv
// Round-robin arbiter: one-hot grant over req, search starts one past the last winner.
// Ports: i_clk, i_reset_n (sync, active-low), req[N_REQ], advance (grant was taken),
//        grant[N_REQ] one-hot, grant_id. Pointer resets to N_REQ-1 so req 0 wins first.
module fxp_rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int ID_W  = $clog2(N_REQ)
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic [N_REQ-1:0] req,
  input  logic             advance,
  output logic [N_REQ-1:0] grant,
  output logic [ID_W-1:0]  grant_id
);

  logic [ID_W-1:0] ptr;
  logic            found;

  always_comb begin
    grant    = '0;
    grant_id = '0;
    found    = 1'b0;
    for (int off = 1; off <= N_REQ; off++) begin
      int idx;
      idx = (int'(ptr) + off) % N_REQ;
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_id   = ID_W'(idx);
      end
    end
  end

  // The pointer only moves when the grant is actually consumed, so a requester
  // held off by backpressure keeps its turn.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      ptr <= ID_W'(N_REQ - 1);
    end else if (advance) begin
      ptr <= grant_id;
    end
  end

endmodule

// File: rtl/fxp_addsub_scheduler.sv
// Shares one signed fixed-point add/sub between N_REQ requesters: RR arbitration,
// s1 operand register then output register (result two edges after transfer).
// Ports: i_req_valid/o_req_ready/i_req_a/i_req_b/i_req_sub per requester (packed),
//        o_rsp_valid/i_rsp_ready/o_rsp_id/o_rsp_data/o_rsp_ovf, o_busy.
module fxp_addsub_scheduler
  import fxp_pkg::*;
#(
  parameter int N_REQ    = 4,
  parameter int DATA_W   = DATA_W_DEF,
  parameter int FRAC_W   = FRAC_W_DEF,
  parameter int SATURATE = 1
) (
  input  logic                      i_clk,
  input  logic                      i_reset_n,
  input  logic [N_REQ-1:0]          i_req_valid,
  output logic [N_REQ-1:0]          o_req_ready,
  input  logic [N_REQ*DATA_W-1:0]   i_req_a,
  input  logic [N_REQ*DATA_W-1:0]   i_req_b,
  input  logic [N_REQ-1:0]          i_req_sub,
  output logic                      o_rsp_valid,
  input  logic                      i_rsp_ready,
  output logic [$clog2(N_REQ)-1:0]  o_rsp_id,
  output logic [DATA_W-1:0]         o_rsp_data,
  output logic                      o_rsp_ovf,
  output logic                      o_busy
);

  localparam int ID_W = $clog2(N_REQ);
  localparam logic [DATA_W-1:0] SAT_MAX = DATA_W'(fxp_sat_max(DATA_W));
  localparam logic [DATA_W-1:0] SAT_MIN = DATA_W'(fxp_sat_min(DATA_W));

  // The binary point is shared by a, b and the result, so add/sub never needs
  // alignment; the fraction width only has to fit inside the word.
  if (FRAC_W < 0 || FRAC_W >= DATA_W) begin : g_bad_frac_w
    $error("FRAC_W must be in [0, DATA_W-1]");
  end

  logic [N_REQ-1:0] grant;
  logic [ID_W-1:0]  grant_id;
  logic             out_free;
  logic             s1_free;
  logic             xfer;

  logic              s1_valid;
  logic [ID_W-1:0]   s1_id;
  logic [DATA_W-1:0] s1_a;
  logic [DATA_W-1:0] s1_b;
  logic              s1_sub;

  logic signed [DATA_W:0] ext_a;
  logic signed [DATA_W:0] ext_b;
  logic signed [DATA_W:0] sum;
  logic                   ovf;
  logic [DATA_W-1:0]      result;

  assign out_free    = !o_rsp_valid || i_rsp_ready;
  assign s1_free     = !s1_valid || out_free;
  assign o_req_ready = grant & {N_REQ{s1_free}};
  assign xfer        = |grant && s1_free;
  assign o_busy      = s1_valid || o_rsp_valid;

  fxp_rr_arbiter #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_arb (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .req       (i_req_valid),
    .advance   (xfer),
    .grant     (grant),
    .grant_id  (grant_id)
  );

  // One extra bit of headroom makes a - (most negative b) exact; overflow is
  // then simply the top two bits disagreeing.
  always_comb begin
    ext_a  = {s1_a[DATA_W-1], s1_a};
    ext_b  = {s1_b[DATA_W-1], s1_b};
    sum    = (s1_sub == OP_SUB) ? (ext_a - ext_b) : (ext_a + ext_b);
    ovf    = sum[DATA_W] ^ sum[DATA_W-1];
    result = sum[DATA_W-1:0];
    if ((SATURATE != 0) && ovf) begin
      result = sum[DATA_W] ? SAT_MIN : SAT_MAX;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      s1_valid    <= 1'b0;
      s1_id       <= '0;
      s1_a        <= '0;
      s1_b        <= '0;
      s1_sub      <= 1'b0;
      o_rsp_valid <= 1'b0;
      o_rsp_id    <= '0;
      o_rsp_data  <= '0;
      o_rsp_ovf   <= 1'b0;
    end else begin
      if (out_free) begin
        o_rsp_valid <= s1_valid;
        // Data fields only change with a new result so a bubble leaves them quiet.
        if (s1_valid) begin
          o_rsp_id   <= s1_id;
          o_rsp_data <= result;
          o_rsp_ovf  <= ovf;
        end
      end
      if (s1_free) begin
        s1_valid <= xfer;
        if (xfer) begin
          s1_id  <= grant_id;
          s1_a   <= i_req_a[grant_id*DATA_W +: DATA_W];
          s1_b   <= i_req_b[grant_id*DATA_W +: DATA_W];
          s1_sub <= i_req_sub[grant_id];
        end
      end
    end
  end

endmodule

// File: tb/tb_fxp_addsub_scheduler.sv
// Bench for fxp_addsub_scheduler: directed vectors, expected responses queued at issue
// time and compared by an independent monitor whenever a response handshakes.
// Covers reset, latency, saturation, wrap mode, fairness, sparse requests, stall, mid-op reset.
module tb_fxp_addsub_scheduler;

  typedef struct packed {
    logic [1:0] id;
    logic [7:0] data;
    logic       ovf;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic [3:0]  req_sub;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [1:0]  rsp_id;
  logic [7:0]  rsp_data;
  logic        rsp_ovf;
  logic        busy;

  logic [3:0]  w_req_valid;
  logic [3:0]  w_req_ready;
  logic [31:0] w_req_a;
  logic [31:0] w_req_b;
  logic [3:0]  w_req_sub;
  logic        w_rsp_valid;
  logic        w_rsp_ready;
  logic [1:0]  w_rsp_id;
  logic [7:0]  w_rsp_data;
  logic        w_rsp_ovf;
  logic        w_busy;

  exp_t sbq[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  fxp_addsub_scheduler #(.N_REQ(4), .DATA_W(8), .FRAC_W(4), .SATURATE(1)) dut (
    .i_clk(clk), .i_reset_n(reset_n),
    .i_req_valid(req_valid), .o_req_ready(req_ready),
    .i_req_a(req_a), .i_req_b(req_b), .i_req_sub(req_sub),
    .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready),
    .o_rsp_id(rsp_id), .o_rsp_data(rsp_data), .o_rsp_ovf(rsp_ovf),
    .o_busy(busy)
  );

  fxp_addsub_scheduler #(.N_REQ(4), .DATA_W(8), .FRAC_W(4), .SATURATE(0)) dut_wrap (
    .i_clk(clk), .i_reset_n(reset_n),
    .i_req_valid(w_req_valid), .o_req_ready(w_req_ready),
    .i_req_a(w_req_a), .i_req_b(w_req_b), .i_req_sub(w_req_sub),
    .o_rsp_valid(w_rsp_valid), .i_rsp_ready(w_rsp_ready),
    .o_rsp_id(w_rsp_id), .o_rsp_data(w_rsp_data), .o_rsp_ovf(w_rsp_ovf),
    .o_busy(w_busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: scoreboard pop on every response handshake, hold check while stalled.
  initial begin : monitor
    logic        pstall;
    logic [11:0] pv;
    exp_t        e;
    pstall = 1'b0;
    pv     = '0;
    forever begin
      @(negedge clk);
      if (reset_n) begin
        if (pstall)
          check("stall_hold", {rsp_valid, rsp_id, rsp_data, rsp_ovf}, pv);
        check("ready_onehot0", 32'($onehot0(req_ready)), 32'd1);
        if (rsp_valid && rsp_ready) begin
          if (sbq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL rsp_unexpected: got id=%0d data=0x%0h, expected no response", rsp_id, rsp_data);
          end else begin
            e = sbq.pop_front();
            check("rsp", {rsp_id, rsp_data, rsp_ovf}, e);
          end
        end
      end
      pstall = reset_n && rsp_valid && !rsp_ready;
      pv     = {rsp_valid, rsp_id, rsp_data, rsp_ovf};
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic set_op(input int i, input logic [7:0] a, input logic [7:0] b, input logic s);
    req_a[i*8 +: 8] = a;
    req_b[i*8 +: 8] = b;
    req_sub[i]      = s;
  endtask

  task automatic push(input logic [1:0] id, input logic [7:0] d, input logic o);
    sbq.push_back('{id: id, data: d, ovf: o});
  endtask

  // Holds the valid mask until n transfers have been seen; returns cycles taken.
  task automatic issue(input logic [3:0] mask, input int n, output int cyc);
    int cnt;
    cnt = 0;
    cyc = 0;
    req_valid = mask;
    while (cnt < n && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (|(req_valid & req_ready)) cnt++;
    end
    check("issue_transfers", 32'(cnt), 32'(n));
    step();
    req_valid = '0;
  endtask

  task automatic drain();
    int k;
    k = 0;
    while ((sbq.size() != 0 || busy) && k < 100) begin
      @(negedge clk);
      k++;
    end
    check("drain_empty", {31'(sbq.size()), busy}, 32'd0);
    step();
  endtask

  initial begin : stim
    int c;
    int k;
    int cnt;
    reset_n     = 1'b0;
    req_valid   = '0;
    req_a       = '0;
    req_b       = '0;
    req_sub     = '0;
    rsp_ready   = 1'b1;
    w_req_valid = '0;
    w_req_a     = '0;
    w_req_b     = '0;
    w_req_sub   = '0;
    w_rsp_ready = 1'b1;
    step();
    step();
    @(negedge clk);
    check("reset_state", {rsp_valid, busy, req_ready, rsp_data, rsp_id, rsp_ovf}, 32'd0);
    step();
    reset_n = 1'b1;
    step();

    // Basic add with latency: result visible after the second edge.
    set_op(0, 8'h10, 8'h08, 1'b0);
    push(2'd0, 8'h18, 1'b0);
    req_valid = 4'b0001;
    @(negedge clk);
    check("t1_ready", 32'(req_ready), 32'h1);
    step();
    req_valid = '0;
    @(negedge clk);
    check("t1_s1_only", {rsp_valid, busy}, 32'b01);
    @(negedge clk);
    check("t1_out_valid", 32'(rsp_valid), 32'd1);
    drain();

    // Wrap mode: overflow flagged, result wraps.
    w_req_a[7:0] = 8'h70;
    w_req_b[7:0] = 8'h20;
    w_req_valid  = 4'b0001;
    step();
    w_req_valid  = '0;
    k = 0;
    while (!w_rsp_valid && k < 10) begin
      @(negedge clk);
      k++;
    end
    check("wrap_rsp", {w_rsp_valid, w_rsp_id, w_rsp_data, w_rsp_ovf}, {1'b1, 2'd0, 8'h90, 1'b1});
    step();

    // Saturation and edge cases through requester 0.
    set_op(0, 8'h70, 8'h20, 1'b0); push(2'd0, 8'h7F, 1'b1); issue(4'b0001, 1, c);
    set_op(0, 8'h80, 8'h01, 1'b1); push(2'd0, 8'h80, 1'b1); issue(4'b0001, 1, c);
    set_op(0, 8'h00, 8'h80, 1'b1); push(2'd0, 8'h7F, 1'b1); issue(4'b0001, 1, c);
    set_op(0, 8'hF0, 8'h08, 1'b0); push(2'd0, 8'hF8, 1'b0); issue(4'b0001, 1, c);
    drain();

    // Reset with s1 and output both occupied.
    rsp_ready = 1'b0;
    set_op(0, 8'h11, 8'h22, 1'b0);
    issue(4'b0001, 2, c);
    @(negedge clk);
    check("t5_full", {rsp_valid, busy, req_ready}, {1'b1, 1'b1, 4'b0000});
    step();
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    @(negedge clk);
    check("t5_after_reset", {rsp_valid, busy}, 32'd0);
    step();
    rsp_ready = 1'b1;

    // Fairness after reset: requester 0 first, back-to-back.
    set_op(0, 8'h10, 8'h08, 1'b0);
    set_op(1, 8'h20, 8'h05, 1'b0);
    set_op(2, 8'h30, 8'h10, 1'b1);
    set_op(3, 8'h01, 8'h02, 1'b0);
    push(2'd0, 8'h18, 1'b0); push(2'd1, 8'h25, 1'b0); push(2'd2, 8'h20, 1'b0);
    push(2'd3, 8'h03, 1'b0); push(2'd0, 8'h18, 1'b0); push(2'd1, 8'h25, 1'b0);
    issue(4'b1111, 6, c);
    check("t3_cycles", 32'(c), 32'd6);
    drain();

    // Sparse: pointer sits at 1, so 3 then 1 then 3.
    set_op(1, 8'h08, 8'h18, 1'b1);
    set_op(3, 8'h7F, 8'h01, 1'b0);
    push(2'd3, 8'h7F, 1'b1); push(2'd1, 8'hF0, 1'b0); push(2'd3, 8'h7F, 1'b1);
    issue(4'b1010, 3, c);
    drain();

    // Backpressure: pointer at 3; stall after two transfers, grant to 2 must hold.
    set_op(1, 8'h20, 8'h05, 1'b0);
    set_op(3, 8'h01, 8'h02, 1'b0);
    push(2'd0, 8'h18, 1'b0); push(2'd1, 8'h25, 1'b0); push(2'd2, 8'h20, 1'b0);
    push(2'd3, 8'h03, 1'b0); push(2'd0, 8'h18, 1'b0); push(2'd1, 8'h25, 1'b0);
    rsp_ready = 1'b0;
    req_valid = 4'b1111;
    cnt = 0;
    k   = 0;
    while (cnt < 2 && k < 50) begin
      @(negedge clk);
      k++;
      if (|(req_valid & req_ready)) cnt++;
    end
    step();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("t4_ready_blocked", {busy, rsp_valid, req_ready}, {1'b1, 1'b1, 4'b0000});
    end
    step();
    rsp_ready = 1'b1;
    while (cnt < 6 && k < 100) begin
      @(negedge clk);
      k++;
      if (|(req_valid & req_ready)) cnt++;
    end
    check("t4_transfers", 32'(cnt), 32'd6);
    step();
    req_valid = '0;
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
